regfile_ctrl: RTL and testbench
===============================

REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero all 32 entries after reset, 0 = skip clearing.
REQ-002 SHALL have port clk, input, 1, the single clock for all logic.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port rd_valid, input, 1, core requests a two-operand read.
REQ-005 SHALL have port rd_ready, output, 1, read request accepted this cycle.
REQ-006 SHALL have ports rs1 and rs2, input, 5 each, read addresses.
REQ-007 SHALL have port rdata_valid, output, 1, rs1_data/rs2_data valid this cycle.
REQ-008 SHALL have ports rs1_data and rs2_data, output, 32 each, read results.
REQ-009 SHALL have port wr_valid, input, 1, core requests a write.
REQ-010 SHALL have port wr_ready, output, 1, write accepted this cycle.
REQ-011 SHALL have ports wr_addr (input, 5) and wr_data (input, 32), write address and data.
REQ-012 SHALL have port init_done, output, 1, clearing complete and requests may be accepted.
REQ-013 SHALL have RAM port-A outputs mem_ada (5), mem_dina (32), mem_wrea (1), mem_cea (1), mem_ocea (1), mem_reseta (1), and input mem_douta (32).
REQ-014 SHALL have RAM port-B outputs mem_adb (5), mem_dinb (32), mem_wreb (1), mem_ceb (1), mem_oceb (1), mem_resetb (1), and input mem_doutb (32).

Function
REQ-015 SHALL drive mem_ocea = mem_oceb = 1 and mem_reseta = mem_resetb = 0 at all times; the RAM has a 1-cycle synchronous read and uses normal write mode.
REQ-016 SHALL implement states INIT and RUN.
REQ-017 INIT: a 4-bit counter k runs 0..15; each cycle write 0 to address 2k on port A and 2k+1 on port B (ce=1, wre=1); after k=15, go to RUN.
REQ-018 If CLEAR_ON_RESET=0, SHALL enter RUN in the first cycle after reset release with no RAM writes.
REQ-019 init_done SHALL be 1 exactly in RUN.
REQ-020 rd_ready and wr_ready SHALL be 0 in INIT.
REQ-021 Write accept: in RUN, a write is accepted when wr_valid=1 and not (rd_valid=1 and owe_read=1).
REQ-022 Read accept: in RUN, a read is accepted when rd_valid=1 and (wr_valid=0 or owe_read=1).
REQ-023 At most one of rd_ready/wr_ready SHALL be 1 per cycle.
REQ-024 owe_read flag: set when a write is accepted while rd_valid=1; cleared on any read accept; reset to 0.
REQ-025 Starvation bound: a continuously asserted read SHALL be accepted within 2 RUN cycles.
REQ-026 Accepted write: drive mem_ada=wr_addr, mem_dina=wr_data, mem_cea=1, and mem_wrea=1 unless wr_addr=0; port B stays idle.
REQ-027 A write with wr_addr=0 SHALL still be accepted (wr_ready=1) but SHALL NOT write the RAM.
REQ-028 Accepted read: drive mem_ada=rs1, mem_adb=rs2, mem_cea=mem_ceb=1, wre=0; register rs1==0 and rs2==0 flags.
REQ-029 rdata_valid SHALL pulse exactly 1 cycle after each read accept, with rs1_data = flag1 ? 0 : mem_douta and rs2_data = flag2 ? 0 : mem_doutb.
REQ-030 rs1_data/rs2_data are valid only while rdata_valid=1; back-to-back reads SHALL give back-to-back rdata_valid pulses.
REQ-031 Write-then-read to the same address in consecutive accept cycles SHALL return the new data, with no bypass needed.
REQ-032 When idle (nothing accepted, RUN), all mem ce and wre outputs SHALL be 0.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=INIT (or RUN-pending if CLEAR_ON_RESET=0), k=0, owe_read=0, and all outputs 0 except mem_ocea/mem_oceb=1.
REQ-034 Reset mid-operation SHALL drop any pending read with no rdata_valid; a RAM write in progress at reset may be lost.
REQ-035 Re-release of reset SHALL restart INIT from k=0.

Verification
REQ-036 Reset release, CLEAR_ON_RESET=1 -> 16 cycles of paired writes (0/1 … 30/31, data 0), init_done=1 on cycle 17; then read rs1=5, rs2=31 -> both data 0.
REQ-037 Write x7=0xDEADBEEF, next cycle read rs1=7, rs2=0 -> rdata_valid one cycle later, rs1_data=0xDEADBEEF, rs2_data=0.
REQ-038 Write x0=0x12345678 -> wr_ready=1, mem_wrea=0; a later read of rs1=0 -> 0.
REQ-039 rd_valid and wr_valid held high for 6 cycles -> accepts alternate W,R,W,R,W,R, with 3 rdata_valid pulses.
REQ-040 rst_n pulled low the cycle after a read accept -> no rdata_valid, init_done=0, INIT restarts at k=0 after release.
REQ-041 CLEAR_ON_RESET=0 -> init_done=1 one cycle after release and no mem_wrea/mem_wreb pulses.

Source files
------------

// File: rtl/regfile_ctrl.sv
// Register-file controller for a 32x32 true-dual-port RAM with 1-cycle
// synchronous read. After reset it optionally zeroes the RAM two entries per
// cycle, then arbitrates one two-operand read or one write per cycle, with a
// fairness flag so a held read is never starved by back-to-back writes.
// Register x0 is hardwired to zero: writes to it are accepted but dropped,
// and reads of it are forced to zero on the way out.
module regfile_ctrl #(
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rdata_valid,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic        init_done,
  output logic [4:0]  mem_ada,
  output logic [31:0] mem_dina,
  output logic        mem_wrea,
  output logic        mem_cea,
  output logic        mem_ocea,
  output logic        mem_reseta,
  input  logic [31:0] mem_douta,
  output logic [4:0]  mem_adb,
  output logic [31:0] mem_dinb,
  output logic        mem_wreb,
  output logic        mem_ceb,
  output logic        mem_oceb,
  output logic        mem_resetb,
  input  logic [31:0] mem_doutb
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  k_reg, k_next;
  logic        owe_read_reg, owe_read_next;
  logic        rd_pend_reg;
  logic        zero1_reg, zero2_reg;

  logic        run;
  logic        clearing;
  logic        rd_accept;
  logic        wr_accept;

  // State, clear counter, fairness flag and read-return pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= INIT;
      k_reg        <= 4'd0;
      owe_read_reg <= 1'b0;
      rd_pend_reg  <= 1'b0;
      zero1_reg    <= 1'b0;
      zero2_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      owe_read_reg <= owe_read_next;
      rd_pend_reg  <= rd_accept;
      if (rd_accept) begin
        zero1_reg <= (rs1 == 5'd0);
        zero2_reg <= (rs2 == 5'd0);
      end
    end
  end

  // Arbitration, next-state logic and RAM port drive.
  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    owe_read_next = owe_read_reg;
    mem_ada       = 5'd0;
    mem_dina      = 32'd0;
    mem_wrea      = 1'b0;
    mem_cea       = 1'b0;
    mem_adb       = 5'd0;
    mem_dinb      = 32'd0;
    mem_wreb      = 1'b0;
    mem_ceb       = 1'b0;

    run = (state_reg == RUN);
    // Reset is asynchronous, so the clear writes must drop with rst_n
    // itself rather than waiting for a clock edge.
    clearing = (state_reg == INIT) && (CLEAR_ON_RESET != 0) && rst_n;

    // A held read wins whenever the previous contested cycle went to a write.
    rd_accept = run && rd_valid && (!wr_valid || owe_read_reg);
    wr_accept = run && wr_valid && !(rd_valid && owe_read_reg);

    if (rd_accept) begin
      owe_read_next = 1'b0;
    end else if (wr_accept && rd_valid) begin
      owe_read_next = 1'b1;
    end

    case (state_reg)
      INIT: begin
        if (CLEAR_ON_RESET == 0) begin
          state_next = RUN;
        end else begin
          k_next = k_reg + 4'd1;
          if (k_reg == 4'd15) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = INIT;
      end
    endcase

    if (clearing) begin
      mem_ada  = {k_reg, 1'b0};
      mem_adb  = {k_reg, 1'b1};
      mem_cea  = 1'b1;
      mem_ceb  = 1'b1;
      mem_wrea = 1'b1;
      mem_wreb = 1'b1;
    end else if (wr_accept) begin
      mem_ada  = wr_addr;
      mem_dina = wr_data;
      mem_cea  = 1'b1;
      mem_wrea = (wr_addr != 5'd0);
    end else if (rd_accept) begin
      mem_ada = rs1;
      mem_adb = rs2;
      mem_cea = 1'b1;
      mem_ceb = 1'b1;
    end
  end

  // Fixed RAM controls and read-result forming; data is zero when not valid.
  always_comb begin
    mem_ocea    = 1'b1;
    mem_oceb    = 1'b1;
    mem_reseta  = 1'b0;
    mem_resetb  = 1'b0;
    rd_ready    = rd_accept;
    wr_ready    = wr_accept;
    init_done   = run;
    rdata_valid = rd_pend_reg;
    rs1_data    = (rd_pend_reg && !zero1_reg) ? mem_douta : 32'd0;
    rs2_data    = (rd_pend_reg && !zero2_reg) ? mem_doutb : 32'd0;
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl. The stimulus pushes hand-computed read
// results when a read is accepted; a monitor pops and compares on every
// rdata_valid pulse. A second instance with CLEAR_ON_RESET=0 shares clock
// and reset and is checked for start-up timing and absence of RAM writes.
module tb_regfile_ctrl;

  logic        clk;
  logic        rst_n;
  logic        rd_valid, wr_valid;
  logic [4:0]  rs1, rs2, wr_addr;
  logic [31:0] wr_data;
  logic        rd_ready, wr_ready, rdata_valid, init_done;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  mem_ada, mem_adb;
  logic [31:0] mem_dina, mem_dinb, mem_douta, mem_doutb;
  logic        mem_wrea, mem_cea, mem_ocea, mem_reseta;
  logic        mem_wreb, mem_ceb, mem_oceb, mem_resetb;

  // second instance, CLEAR_ON_RESET=0, kept idle
  logic        rd_valid1, wr_valid1;
  logic        rd_ready1, wr_ready1, rdata_valid1, init_done1;
  logic [31:0] rs1_data1, rs2_data1;
  logic [4:0]  mem_ada1, mem_adb1;
  logic [31:0] mem_dina1, mem_dinb1, mem_douta1, mem_doutb1;
  logic        mem_wrea1, mem_cea1, mem_ocea1, mem_reseta1;
  logic        mem_wreb1, mem_ceb1, mem_oceb1, mem_resetb1;

  int          n_cmp;
  int          n_err;
  int          n_pulse;
  int          n_push;
  int          wr1_cnt;
  logic        rd_prev;
  logic [63:0] exp_q[$];
  logic [31:0] mem0 [32];

  regfile_ctrl #(.CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rs1(rs1), .rs2(rs2),
    .rdata_valid(rdata_valid), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_done(init_done),
    .mem_ada(mem_ada), .mem_dina(mem_dina), .mem_wrea(mem_wrea), .mem_cea(mem_cea),
    .mem_ocea(mem_ocea), .mem_reseta(mem_reseta), .mem_douta(mem_douta),
    .mem_adb(mem_adb), .mem_dinb(mem_dinb), .mem_wreb(mem_wreb), .mem_ceb(mem_ceb),
    .mem_oceb(mem_oceb), .mem_resetb(mem_resetb), .mem_doutb(mem_doutb)
  );

  regfile_ctrl #(.CLEAR_ON_RESET(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid1), .rd_ready(rd_ready1), .rs1(5'd3), .rs2(5'd4),
    .rdata_valid(rdata_valid1), .rs1_data(rs1_data1), .rs2_data(rs2_data1),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(5'd3), .wr_data(32'h5555_AAAA),
    .init_done(init_done1),
    .mem_ada(mem_ada1), .mem_dina(mem_dina1), .mem_wrea(mem_wrea1), .mem_cea(mem_cea1),
    .mem_ocea(mem_ocea1), .mem_reseta(mem_reseta1), .mem_douta(mem_douta1),
    .mem_adb(mem_adb1), .mem_dinb(mem_dinb1), .mem_wreb(mem_wreb1), .mem_ceb(mem_ceb1),
    .mem_oceb(mem_oceb1), .mem_resetb(mem_resetb1), .mem_doutb(mem_doutb1)
  );

  assign rd_valid1  = 1'b0;
  assign wr_valid1  = 1'b0;
  assign mem_douta1 = 32'd0;
  assign mem_doutb1 = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 1-cycle synchronous read, write-first; filled with nonzero
  // junk while reset is low so that the clear sequence is observable.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem0[i] <= (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    end else begin
      if (mem_cea) begin
        if (mem_wrea) begin
          mem0[mem_ada] <= mem_dina;
          mem_douta     <= mem_dina;
        end else begin
          mem_douta <= mem0[mem_ada];
        end
      end
      if (mem_ceb) begin
        if (mem_wreb) begin
          mem0[mem_adb] <= mem_dinb;
          mem_doutb     <= mem_dinb;
        end else begin
          mem_doutb <= mem0[mem_adb];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mem_wrea1 || mem_wreb1) wr1_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every rdata_valid pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rdata_valid) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rdata_unexpected: got %h_%h expected no pulse", rs1_data, rs2_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        $display("read result %h %h", rs1_data, rs2_data);
        check("rdata", {rs1_data, rs2_data}, e);
      end
    end
  end

  // Tasks are entered 1 time unit after a rising edge and return there.
  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    $display("write x%0d <= %h ready=%0b", a, d, wr_ready);
    check("wr_ready", 64'(wr_ready), 64'd1);
    check("wr_wrea", {mem_cea, mem_wrea, mem_ceb, mem_wreb}, {2'b1, (a != 5'd0), 2'b00});
    check("rdata_valid_timing", 64'(rdata_valid), 64'(rd_prev));
    rd_prev = 1'b0;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
    rd_valid = 1'b1; rs1 = a1; rs2 = a2;
    @(negedge clk);
    $display("read x%0d x%0d ready=%0b", a1, a2, rd_ready);
    check("rd_ready", 64'(rd_ready), 64'd1);
    check("rdata_valid_timing", 64'(rdata_valid), 64'(rd_prev));
    if (rd_ready) begin
      exp_q.push_back({e1, e2});
      n_push++;
    end
    rd_prev = rd_ready;
    @(posedge clk); #1;
    rd_valid = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("idle_mem_ctrl",
          {mem_cea, mem_ceb, mem_wrea, mem_wreb, mem_ocea, mem_oceb, mem_reseta, mem_resetb},
          64'b0000_1100);
    check("rdata_valid_timing", 64'(rdata_valid), 64'(rd_prev));
    rd_prev = 1'b0;
    @(posedge clk); #1;
  endtask

  // Entered right after reset release with both valids held high.
  task automatic check_init();
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (init_done || rd_ready || wr_ready || rdata_valid ||
          mem_ada !== 5'(2 * k) || mem_adb !== 5'(2 * k + 1) ||
          !mem_cea || !mem_ceb || !mem_wrea || !mem_wreb ||
          mem_dina !== 32'd0 || mem_dinb !== 32'd0) bad++;
      if (k < 2) check("dut1_init_done", 64'(init_done1), 64'(k == 1));
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    $display("init sequence: %0d bad cycles, init_done=%0b", bad, init_done);
    check("init_seq_bad_cycles", 64'(bad), 64'd0);
    check("init_done", 64'(init_done), 64'd1);
    rd_prev = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; n_pulse = 0; n_push = 0; wr1_cnt = 0;
    rd_prev = 1'b0;
    rst_n = 1'b0;
    rd_valid = 1'b1; wr_valid = 1'b1;
    rs1 = 5'd1; rs2 = 5'd2; wr_addr = 5'd3; wr_data = 32'h1111_2222;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {init_done, rd_ready, wr_ready, rdata_valid, mem_cea, mem_ceb, mem_wrea, mem_wreb,
           mem_ocea, mem_oceb, mem_reseta, mem_resetb},
          64'b0000_0000_1100);
    check("reset_rdata", {rs1_data, rs2_data}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_init();
    idle_check();

    // cleared entries read back as zero
    do_read(5'd5, 5'd31, 32'd0, 32'd0);
    // write then immediate read of the same register
    do_write(5'd7, 32'hDEAD_BEEF);
    do_read(5'd7, 5'd0, 32'hDEAD_BEEF, 32'd0);
    // x0 write is accepted but never lands
    do_write(5'd0, 32'h1234_5678);
    do_read(5'd0, 5'd7, 32'd0, 32'hDEAD_BEEF);
    // back-to-back reads after two writes
    do_write(5'd12, 32'hCAFE_F00D);
    do_write(5'd13, 32'h0BAD_C0DE);
    do_read(5'd12, 5'd13, 32'hCAFE_F00D, 32'h0BAD_C0DE);
    do_read(5'd13, 5'd12, 32'h0BAD_C0DE, 32'hCAFE_F00D);
    do_read(5'd31, 5'd7, 32'd0, 32'hDEAD_BEEF);
    idle_check();

    // contention: both valids held, accepts alternate W,R,W,R,W,R
    rd_valid = 1'b1; wr_valid = 1'b1;
    wr_addr = 5'd9; rs1 = 5'd9; rs2 = 5'd7;
    for (int i = 0; i < 6; i++) begin
      wr_data = 32'h1000_0000 + 32'(i);
      @(negedge clk);
      $display("contend cycle %0d rd_ready=%0b wr_ready=%0b", i, rd_ready, wr_ready);
      check("alt_ready", {rd_ready, wr_ready}, (i % 2 == 1) ? 2'b10 : 2'b01);
      check("rdata_valid_timing", 64'(rdata_valid), 64'(rd_prev));
      if (rd_ready) begin
        exp_q.push_back({32'h1000_0000 + 32'(i - 1), 32'hDEAD_BEEF});
        n_push++;
      end
      rd_prev = rd_ready;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0; wr_valid = 1'b0;
    idle_check();

    // reset right after a read accept drops the pending result
    rd_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd0;
    @(negedge clk);
    $display("read x7 x0 before reset ready=%0b", rd_ready);
    check("pre_reset_rd_ready", 64'(rd_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rd_valid = 1'b0;
    rd_prev = 1'b0;
    @(negedge clk);
    check("midreset_outputs", {rdata_valid, init_done, init_done1, mem_cea, mem_wrea}, 64'd0);
    @(posedge clk); #1;
    rd_valid = 1'b1; wr_valid = 1'b1;
    rst_n = 1'b1;
    check_init();
    // x7 was cleared again by the restarted INIT
    do_read(5'd7, 5'd9, 32'd0, 32'd0);
    idle_check();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("pulse_count", 64'(n_pulse), 64'(n_push));
    check("dut1_ram_writes", 64'(wr1_cnt), 64'd0);
    check("dut1_init_done_final", 64'(init_done1), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
